// File: rtl/cluster_expander.sv
// Purpose : rebuilds a per-pad hit map (valid flag + 3-bit count) from 8 clusters per frame.
// Latency : a cluster sampled in phase p appears on vpfs/cnts 8-p cycles later.
// Backpr. : none; one cluster is accepted every cycle, and the output frame is held until the next one.
//
// Ports:
//   clock, global_reset_n  - single clock, async active-low reset
//   sync                   - forces the next cycle to be phase 0 and discards the current frame
//   adr, cnt               - cluster first-pad address (0x7FE = none) and its count word
//   phase                  - phase (0..7) of the cluster now on adr/cnt
//   vpfs, cnts             - registered per-pad flags / counts of the last completed frame
//   frame_valid            - one-cycle pulse when vpfs/cnts/n_clusters/dup_err were reloaded
//   n_clusters, dup_err    - accepted-cluster count and duplicate-pad flag of that frame
module cluster_expander #(
   parameter int MXPADS    = 1536,
   parameter int MXADRBITS = 11
) (
   input  logic                  clock,
   input  logic                  global_reset_n,
   input  logic                  sync,
   input  logic [MXADRBITS-1:0]  adr,
   input  logic [2:0]            cnt,
   output logic [2:0]            phase,
   output logic [MXPADS-1:0]     vpfs,
   output logic [MXPADS*3-1:0]   cnts,
   output logic                  frame_valid,
   output logic [3:0]            n_clusters,
   output logic                  dup_err
);

   localparam int VW = $clog2(MXPADS);
   localparam int CW = $clog2(MXPADS*3);
   localparam logic [MXADRBITS:0] PAD_LIM = (MXADRBITS+1)'(MXPADS);

   // frame accumulator
   logic [MXPADS-1:0]   acc_vpf;
   logic [MXPADS*3-1:0] acc_cnt;
   logic [3:0]          acc_n;
   logic                acc_err;

   // accumulator merged with the cluster on adr/cnt this cycle
   logic [MXPADS-1:0]   mrg_vpf;
   logic [MXPADS*3-1:0] mrg_cnt;
   logic [3:0]          mrg_n;
   logic                mrg_err;

   logic                valid;
   logic                hit;
   logic [VW-1:0]       vidx;
   logic [CW-1:0]       cbase;

   // Markers 0x7FE/0x7FF and any out-of-range address fall out of this compare.
   assign valid = ({1'b0, adr} < PAD_LIM);
   assign vidx  = VW'(adr);
   assign cbase = CW'(vidx) * CW'(3);
   assign hit   = valid && acc_vpf[vidx];

   always_comb begin
      mrg_vpf = acc_vpf;
      mrg_cnt = acc_cnt;
      // a duplicate keeps the earlier phase's count but is still counted
      if (valid && !hit) begin
         mrg_vpf[vidx]       = 1'b1;
         mrg_cnt[cbase +: 3] = cnt;
      end
      mrg_n   = acc_n + {3'b000, valid};
      mrg_err = acc_err | hit;
   end

   always_ff @(posedge clock or negedge global_reset_n) begin
      if (!global_reset_n) begin
         phase       <= 3'd0;
         acc_vpf     <= '0;
         acc_cnt     <= '0;
         acc_n       <= 4'd0;
         acc_err     <= 1'b0;
         vpfs        <= '0;
         cnts        <= '0;
         frame_valid <= 1'b0;
         n_clusters  <= 4'd0;
         dup_err     <= 1'b0;
      end else if (sync) begin
         // realignment wins over a phase-7 update: the frame is dropped
         phase       <= 3'd0;
         acc_vpf     <= '0;
         acc_cnt     <= '0;
         acc_n       <= 4'd0;
         acc_err     <= 1'b0;
         frame_valid <= 1'b0;
      end else if (phase == 3'd7) begin
         phase       <= 3'd0;
         vpfs        <= mrg_vpf;
         cnts        <= mrg_cnt;
         n_clusters  <= mrg_n;
         dup_err     <= mrg_err;
         frame_valid <= 1'b1;
         acc_vpf     <= '0;
         acc_cnt     <= '0;
         acc_n       <= 4'd0;
         acc_err     <= 1'b0;
      end else begin
         phase       <= phase + 3'd1;
         acc_vpf     <= mrg_vpf;
         acc_cnt     <= mrg_cnt;
         acc_n       <= mrg_n;
         acc_err     <= mrg_err;
         frame_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cluster_expander.sv
// Purpose : directed + random frames against cluster_expander, checked through a frame scoreboard.
// Latency : expected frames are queued at the phase-7 drive and consumed on frame_valid.
// Backpr. : not applicable.
module tb_cluster_expander;

   localparam int NP = 1536;

   logic            clock;
   logic            global_reset_n;
   logic            sync;
   logic [10:0]     adr;
   logic [2:0]      cnt;
   logic [2:0]      phase;
   logic [NP-1:0]   vpfs;
   logic [NP*3-1:0] cnts;
   logic            frame_valid;
   logic [3:0]      n_clusters;
   logic            dup_err;

   cluster_expander #(.MXPADS(NP), .MXADRBITS(11)) dut (
      .clock          (clock),
      .global_reset_n (global_reset_n),
      .sync           (sync),
      .adr            (adr),
      .cnt            (cnt),
      .phase          (phase),
      .vpfs           (vpfs),
      .cnts           (cnts),
      .frame_valid    (frame_valid),
      .n_clusters     (n_clusters),
      .dup_err        (dup_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [NP-1:0]   v;
      logic [NP*3-1:0] c;
      logic [3:0]      n;
      logic            e;
   } frame_t;

   frame_t sb[$];
   frame_t prev;

   int n_cmp = 0;
   int n_bad = 0;
   int n_pushed = 0;
   int n_seen = 0;

   // reference frame accumulator
   logic [NP-1:0]   m_v;
   logic [NP*3-1:0] m_c;
   logic [3:0]      m_n;
   logic            m_e;
   logic [2:0]      m_phase;

   logic [10:0]     fa [8];
   logic [2:0]      fc [8];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_map(input string tag, input logic [NP-1:0] ov, input logic [NP*3-1:0] oc,
                          input logic [NP-1:0] ev, input logic [NP*3-1:0] ec);
      int bad_pad;
      bad_pad = -1;
      for (int i = NP-1; i >= 0; i--)
         if (ov[i] !== ev[i] || oc[i*3 +: 3] !== ec[i*3 +: 3]) bad_pad = i;
      n_cmp++;
      assert (ov === ev && oc === ec) else begin
         n_bad++;
         $error("FAIL %s: pad %0d observed vpf=%b cnt=%0d expected vpf=%b cnt=%0d",
                tag, bad_pad, ov[bad_pad], oc[bad_pad*3 +: 3], ev[bad_pad], ec[bad_pad*3 +: 3]);
      end
   endtask

   task automatic model_clear();
      m_v = '0; m_c = '0; m_n = 4'd0; m_e = 1'b0;
   endtask

   // one cycle: check phase, drive, update reference, clock, check the pulse
   task automatic step(input logic [10:0] a, input logic [2:0] c, input logic s);
      logic last;
      int   ai;
      chk("phase", {13'd0, phase}, {13'd0, m_phase});
      adr = a; cnt = c; sync = s;
      last = (m_phase == 3'd7) && !s;
      ai = int'(a);
      if (s) begin
         model_clear();
         m_phase = 3'd0;
      end else begin
         if (ai < NP) begin
            m_n = m_n + 4'd1;
            if (m_v[ai]) m_e = 1'b1;
            else begin
               m_v[ai] = 1'b1;
               m_c[ai*3 +: 3] = c;
            end
         end
         if (last) begin
            prev = '{v: m_v, c: m_c, n: m_n, e: m_e};
            sb.push_back(prev);
            n_pushed++;
            model_clear();
         end
         m_phase = m_phase + 3'd1;
      end
      @(posedge clock); #1;
      chk("frame_valid", {15'd0, frame_valid}, {15'd0, last});
   endtask

   task automatic clear_frame();
      for (int i = 0; i < 8; i++) begin
         fa[i] = 11'h7FE;
         fc[i] = 3'd0;
      end
   endtask

   task automatic run_frame(input logic sync7);
      for (int i = 0; i < 8; i++)
         step(fa[i], fc[i], (i == 7) ? sync7 : 1'b0);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk_map(tag, vpfs, cnts, '0, '0);
      chk({tag, "_n"}, {12'd0, n_clusters}, 16'd0);
      chk({tag, "_dup"}, {15'd0, dup_err}, 16'd0);
      chk({tag, "_fv"}, {15'd0, frame_valid}, 16'd0);
      chk({tag, "_phase"}, {13'd0, phase}, 16'd0);
   endtask

   // scoreboard consumer
   always @(negedge clock) begin
      if (global_reset_n && frame_valid) begin
         n_seen++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL unexpected_frame: observed frame_valid=1 expected 0 (no frame queued)");
         end else begin
            frame_t e;
            e = sb.pop_front();
            chk_map("frame_map", vpfs, cnts, e.v, e.c);
            chk("n_clusters", {12'd0, n_clusters}, {12'd0, e.n});
            chk("dup_err", {15'd0, dup_err}, {15'd0, e.e});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no end of stimulus, expected $finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      global_reset_n = 1'b0;
      sync = 1'b0; adr = 11'h7FE; cnt = 3'd0;
      model_clear();
      m_phase = 3'd0;
      prev = '{v: '0, c: '0, n: 4'd0, e: 1'b0};
      #12;
      check_zero_outputs("reset");
      @(negedge clock);
      global_reset_n = 1'b1;

      // empty frames: pulse every 8th cycle with an empty map
      clear_frame();
      run_frame(1'b0);
      run_frame(1'b0);

      // lowest-used and top pad
      clear_frame();
      fa[0] = 11'd5;    fc[0] = 3'd3;
      fa[4] = 11'd1535; fc[4] = 3'd7;
      run_frame(1'b0);
      chk("pad5_cnt", {13'd0, cnts[17:15]}, 16'd3);
      chk("pad1535_cnt", {13'd0, cnts[4607:4605]}, 16'd7);
      chk("pad6_vpf", {15'd0, vpfs[6]}, 16'd0);

      // duplicate pad keeps the first count
      clear_frame();
      fa[1] = 11'd100; fc[1] = 3'd2;
      fa[6] = 11'd100; fc[6] = 3'd5;
      run_frame(1'b0);
      chk("pad100_cnt", {13'd0, cnts[302:300]}, 16'd2);
      chk("dup_set", {15'd0, dup_err}, 16'd1);

      // clean frame clears the flag
      clear_frame();
      fa[0] = 11'd7; fc[0] = 3'd1;
      run_frame(1'b0);
      chk("dup_clear", {15'd0, dup_err}, 16'd0);

      // out-of-range and marker addresses ignored
      clear_frame();
      fa[2] = 11'd1536; fc[2] = 3'd4;
      fa[3] = 11'h7FF;  fc[3] = 3'd6;
      fa[5] = 11'd200;  fc[5] = 3'd4;
      fa[7] = 11'd1535; fc[7] = 3'd1;
      run_frame(1'b0);

      // sync at phase 7 drops the frame, outputs hold
      clear_frame();
      fa[0] = 11'd10; fc[0] = 3'd1;
      fa[3] = 11'd20; fc[3] = 3'd2;
      fa[7] = 11'd30; fc[7] = 3'd3;
      run_frame(1'b1);
      chk_map("hold_map", vpfs, cnts, prev.v, prev.c);
      chk("hold_n", {12'd0, n_clusters}, {12'd0, prev.n});
      chk("sync_phase", {13'd0, phase}, 16'd0);
      clear_frame();
      fa[0] = 11'd40; fc[0] = 3'd6;
      run_frame(1'b0);
      chk("pad10_gone", {15'd0, vpfs[10]}, 16'd0);

      // reset in phase 3 after valid clusters
      step(11'd41, 3'd1, 1'b0);
      step(11'd42, 3'd2, 1'b0);
      step(11'd43, 3'd3, 1'b0);
      global_reset_n = 1'b0;
      #1;
      check_zero_outputs("midreset");
      model_clear();
      m_phase = 3'd0;
      @(negedge clock);
      global_reset_n = 1'b1;
      clear_frame();
      fa[0] = 11'd50; fc[0] = 3'd5;
      fa[7] = 11'd51; fc[7] = 3'd2;
      run_frame(1'b0);
      chk("pad41_gone", {15'd0, vpfs[41]}, 16'd0);

      // random frames; the first uses a narrow range to provoke duplicates
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) fa[i] = 11'($urandom_range(1530, 2047));
            else if (r == 0)               fa[i] = 11'($urandom_range(0, 7));
            else                           fa[i] = 11'($urandom_range(0, 1535));
            fc[i] = 3'($urandom_range(0, 7));
         end
         run_frame(1'b0);
      end

      @(negedge clock); #1;
      chk("sb_empty", 16'(sb.size()), 16'd0);
      chk("frames_seen", 16'(n_seen), 16'(n_pushed));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cluster_expander.md
CLUSTER_EXPANDER -- requirements
Module: cluster_expander

Interface
REQ-001 Parameter MXPADS, default 1536, number of pads in the reconstructed hit map.
REQ-002 Parameter MXADRBITS, default 11, width of the cluster address.
REQ-003 Port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port global_reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port sync  input  1  frame alignment; high forces the next cycle to be phase 0.
REQ-006 Port adr  input  MXADRBITS  cluster first-pad address for the current phase; 0x7FE is the no-cluster marker.
REQ-007 Port cnt  input  3  cluster count word carried with adr.
REQ-008 Port phase  output  3  phase (0..7) of the cluster currently on adr/cnt.
REQ-009 Port vpfs  output  MXPADS  reconstructed per-pad valid-pattern flags for the last completed frame.
REQ-010 Port cnts  output  MXPADS*3  reconstructed per-pad count words; pad i occupies bits [3i+2:3i].
REQ-011 Port frame_valid  output  1  one-cycle pulse; vpfs/cnts/n_clusters/dup_err were updated this cycle.
REQ-012 Port n_clusters  output  4  number of accepted clusters in the last completed frame, 0..8.
REQ-013 Port dup_err  output  1  last completed frame contained a cluster addressing an already-set pad.

Function
REQ-014 Frame = 8 consecutive cycles, phase 0..7; one cluster (adr, cnt) is presented per phase.
REQ-015 phase increments by 1 each cycle and wraps 7 -> 0.
REQ-016 sync=1 sampled at an edge: phase becomes 0; accumulator, per-frame count and per-frame error flag clear; that cycle's cluster is discarded.
REQ-017 A cluster is valid iff adr < MXPADS; 0x7FE, 0x7FF and any adr >= MXPADS are ignored without error and are not counted.
REQ-018 A valid cluster with accumulator pad adr clear: set acc_vpf[adr]=1, acc_cnt[adr]=cnt, increment the per-frame count.
REQ-019 A valid cluster with acc_vpf[adr] already set: the earlier phase's cnt is kept, the count still increments, the per-frame error flag sets.
REQ-020 At the edge sampling phase 7 (sync=0): vpfs/cnts <= accumulator merged with the phase-7 cluster per REQ-018/019; n_clusters and dup_err load the final per-frame values; frame_valid <= 1; accumulator, count and error flag clear in the same edge.
REQ-021 frame_valid is 0 in every other cycle; vpfs, cnts, n_clusters and dup_err hold between updates.
REQ-022 Latency: a cluster presented in phase p appears on the outputs in the cycle after the phase-7 edge, i.e. 8-p cycles after its sampling edge.
REQ-023 sync=1 at the phase-7 edge takes priority: no output update, frame_valid stays 0, the frame is discarded.
REQ-024 Only the pad at adr is written per cluster; cnt is stored verbatim and never expands to neighbouring pads.
REQ-025 Pads not addressed in a frame read vpfs=0 and cnts=0 after the update.
REQ-026 Output registers drive vpfs/cnts directly; no combinational path from adr/cnt to any output.

Reset
REQ-027 global_reset_n low asynchronously forces phase=0, accumulator=0, vpfs=0, cnts=0, frame_valid=0, n_clusters=0, dup_err=0.
REQ-028 After release, the first rising edge samples phase 0; the first frame_valid occurs at the 8th edge unless sync intervenes.
REQ-029 Reset asserted mid-frame discards the partial frame; no frame_valid is produced for it.

Verification
REQ-030 Reset release, adr=0x7FE every phase -> frame_valid every 8th cycle, vpfs=0, n_clusters=0, dup_err=0.
REQ-031 Phase 0 adr=5 cnt=3, phase 4 adr=1535 cnt=7, other phases 0x7FE -> vpfs bits 5 and 1535 set only, cnts[17:15]=3, cnts[4607:4605]=7, n_clusters=2.
REQ-032 Phase 1 adr=100 cnt=2, phase 6 adr=100 cnt=5 -> vpfs[100]=1, cnt of pad 100 = 2, n_clusters=2, dup_err=1; the next clean frame -> dup_err=0.
REQ-033 adr=1536 and adr=0x7FF in phases 2 and 3 -> ignored, n_clusters excludes them, dup_err=0.
REQ-034 sync pulsed at phase 7 with valid clusters loaded -> no frame_valid that cycle, outputs hold the previous frame, next cycle phase=0, following frame excludes the discarded clusters.
REQ-035 global_reset_n pulsed low at phase 3 after valid clusters -> all outputs 0 immediately; the first frame after release contains only post-reset clusters.
